// File: rtl/ysyx_23060184_axi_sram_if.sv
// ysyx_23060184_axi_sram_if: AXI4 single-beat bus bundle between the memory initiator and the SRAM responder
// Channels: AR/R (read address, read data), AW/W/B (write address, write data, write response).
// master drives requests and response readys; slave drives request readys and responses.
interface ysyx_23060184_axi_sram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [2:0]              arsize;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [2:0]              awsize;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arid, arsize, arvalid, input arready,
        input rdata, rresp, rid, rlast, rvalid, output rready,
        output awaddr, awid, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bid, bvalid, output bready
    );

    modport slave (
        input araddr, arid, arsize, arvalid, output arready,
        output rdata, rresp, rid, rlast, rvalid, input rready,
        input awaddr, awid, awsize, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bid, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_23060184_axi_sram.sv
// ysyx_23060184_axi_sram: AXI4 single-beat responder over a word-addressed SRAM with fixed access latency
// clk  : rising-edge clock for all state
// rstn : asynchronous active-low reset of control and output registers (memory contents are kept)
// bus  : slave end of the AXI bundle; one read (AR->R) or one write (AW->W->B) in flight at a time
module ysyx_23060184_axi_sram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    LATENCY    = 2
) (
    input logic                    clk,
    input logic                    rstn,
    ysyx_23060184_axi_sram_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 2);

    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, off;
    logic [ID_WIDTH-1:0]   id;
    logic [2:0]            size;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [1:0]            resp, wresp;
    logic                  last_rd, ar_go, aw_go, w_go, in_range, misaligned;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign off        = addr - BASE;
    assign idx        = off[IW+1:2];
    assign in_range   = addr >= BASE && off < ADDR_WIDTH'(4 * DEPTH);
    assign misaligned = size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    assign resp       = !in_range ? 2'b11 : misaligned ? 2'b10 : 2'b00;
    assign wresp      = resp != 2'b00 ? resp : bus.wlast ? 2'b00 : 2'b10;

    // On a simultaneous AR/AW the side that did not win last time gets the grant.
    assign bus.arready = rstn && state == IDLE && !(bus.awvalid && last_rd);
    assign bus.awready = rstn && state == IDLE && !(bus.arvalid && !last_rd);
    assign bus.wready  = state == W_DATA;
    assign bus.rvalid  = state == R_RESP;
    assign bus.bvalid  = state == B_RESP;
    assign ar_go       = bus.arready && bus.arvalid;
    assign aw_go       = bus.awready && bus.awvalid;
    assign w_go        = bus.wready && bus.wvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ar_go ? R_WAIT : aw_go ? W_DATA : IDLE;
            R_WAIT:  state_n = cnt == '0 ? R_RESP : R_WAIT;
            R_RESP:  state_n = bus.rready ? IDLE : R_RESP;
            W_DATA:  state_n = bus.wvalid ? W_WAIT : W_DATA;
            W_WAIT:  state_n = cnt == '0 ? B_RESP : W_WAIT;
            B_RESP:  state_n = bus.bready ? IDLE : B_RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr      <= '0;
            id        <= '0;
            size      <= '0;
            cnt       <= '0;
            last_rd   <= 1'b0;
            bus.rdata <= '0;
            bus.rresp <= 2'b00;
            bus.rid   <= '0;
            bus.rlast <= 1'b0;
            bus.bresp <= 2'b00;
            bus.bid   <= '0;
        end else begin
            if (ar_go) begin
                addr    <= bus.araddr;
                id      <= bus.arid;
                size    <= bus.arsize;
                last_rd <= 1'b1;
            end
            if (aw_go) begin
                addr    <= bus.awaddr;
                id      <= bus.awid;
                size    <= bus.awsize;
                last_rd <= 1'b0;
            end
            if (ar_go || w_go)
                cnt <= CW'(LATENCY);
            else if ((state == R_WAIT || state == W_WAIT) && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == R_WAIT && cnt == '0) begin
                bus.rdata <= resp == 2'b00 ? mem[idx] : '0;
                bus.rresp <= resp;
                bus.rid   <= id;
                bus.rlast <= 1'b1;
            end
            if (w_go) begin
                bus.bresp <= wresp;
                bus.bid   <= id;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (w_go && wresp == 2'b00 && bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ysyx_23060184_axi_sram.sv
// tb_ysyx_23060184_axi_sram: directed self-checking bench for the AXI SRAM responder
module tb_ysyx_23060184_axi_sram;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060184_axi_sram_if bus ();
    ysyx_23060184_axi_sram dut (.clk(clk), .rstn(rstn), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_req(input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz);
        int n = 0;
        bus.araddr = a; bus.arid = id; bus.arsize = sz; bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 50) begin step(); n++; end
        step();
        bus.arvalid = 1'b0;
    endtask

    task automatic r_resp(output logic [31:0] d, output logic [1:0] r, output logic [3:0] i, output int lat);
        lat = 0;
        while (!bus.rvalid && lat < 50) begin step(); lat++; end
        d = bus.rdata; r = bus.rresp; i = bus.rid;
        check("rlast", 32'(bus.rlast), 32'd1);
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic aw_req(input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz);
        int n = 0;
        bus.awaddr = a; bus.awid = id; bus.awsize = sz; bus.awvalid = 1'b1;
        #1;
        while (!bus.awready && n < 50) begin step(); n++; end
        step();
        bus.awvalid = 1'b0;
    endtask

    task automatic wb(input logic [31:0] d, input logic [3:0] s, input logic l,
                      output logic [1:0] r, output logic [3:0] i, output int lat);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin step(); n++; end
        step();
        bus.wvalid = 1'b0;
        lat = 0;
        while (!bus.bvalid && lat < 50) begin step(); lat++; end
        r = bus.bresp; i = bus.bid;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz,
                      input logic [31:0] d, input logic [3:0] s, input logic l, input logic [1:0] er);
        logic [1:0] r;
        logic [3:0] i;
        int         lat;
        aw_req(a, id, sz);
        check({tag, ".wready"}, 32'(bus.wready), 32'd1);
        wb(d, s, l, r, i, lat);
        check({tag, ".bresp"}, 32'(r), 32'(er));
        check({tag, ".bid"}, 32'(i), 32'(id));
        check({tag, ".blat"}, lat, 32'd3);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz,
                      input logic [31:0] ed, input logic [1:0] er, input bit chk_d);
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  i;
        int          lat;
        ar_req(a, id, sz);
        check({tag, ".arready_busy"}, 32'(bus.arready), 32'd0);
        r_resp(d, r, i, lat);
        check({tag, ".rresp"}, 32'(r), 32'(er));
        check({tag, ".rid"}, 32'(i), 32'(id));
        check({tag, ".rlat"}, lat, 32'd3);
        if (chk_d) check({tag, ".rdata"}, d, ed);
        check({tag, ".arready_idle"}, 32'(bus.arready), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  i;
        int          lat;
        bus.araddr = '0; bus.arid = '0; bus.arsize = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awid = '0; bus.awsize = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        #1;
        check("rst.arready_low", 32'(bus.arready), 32'd0);
        check("rst.awready_low", 32'(bus.awready), 32'd0);
        do_reset();
        #1;
        check("rst.arready", 32'(bus.arready), 32'd1);
        check("rst.awready", 32'(bus.awready), 32'd1);
        check("rst.wready", 32'(bus.wready), 32'd0);
        check("rst.rvalid", 32'(bus.rvalid), 32'd0);
        check("rst.bvalid", 32'(bus.bvalid), 32'd0);
        check("rst.rdata", bus.rdata, 32'd0);
        check("rst.rresp", 32'(bus.rresp), 32'd0);
        check("rst.rid", 32'(bus.rid), 32'd0);
        check("rst.rlast", 32'(bus.rlast), 32'd0);
        check("rst.bresp", 32'(bus.bresp), 32'd0);
        check("rst.bid", 32'(bus.bid), 32'd0);

        wr("w0", 32'h8000_0010, 4'd1, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00);
        rd("r0", 32'h8000_0010, 4'd2, 3'd2, 32'hDEAD_BEEF, 2'b00, 1'b1);
        wr("wbyte", 32'h8000_0011, 4'd4, 3'd0, 32'h0000_AA00, 4'b0010, 1'b1, 2'b00);
        rd("rbyte", 32'h8000_0010, 4'd6, 3'd2, 32'hDEAD_AAEF, 2'b00, 1'b1);
        rd("rhalf", 32'h8000_0012, 4'd5, 3'd1, 32'hDEAD_AAEF, 2'b00, 1'b1);
        rd("dec", 32'h9000_0000, 4'd1, 3'd2, 32'd0, 2'b11, 1'b1);
        rd("decmis", 32'h9000_0001, 4'd1, 3'd2, 32'd0, 2'b11, 1'b1);
        rd("below", 32'h7FFF_FFFC, 4'd0, 3'd2, 32'd0, 2'b11, 1'b1);
        rd("top", 32'h8000_0FFC, 4'd1, 3'd2, 32'd0, 2'b00, 1'b0);
        rd("past", 32'h8000_1000, 4'd2, 3'd2, 32'd0, 2'b11, 1'b1);
        rd("misw", 32'h8000_0002, 4'd2, 3'd2, 32'd0, 2'b10, 1'b1);
        rd("mish", 32'h8000_0011, 4'd3, 3'd1, 32'd0, 2'b10, 1'b1);
        rd("big", 32'h8000_0010, 4'd4, 3'd3, 32'd0, 2'b10, 1'b1);
        wr("wnolast", 32'h8000_0010, 4'd8, 3'd2, 32'h1111_1111, 4'hF, 1'b0, 2'b10);
        wr("wdec", 32'h9000_0000, 4'hA, 3'd2, 32'h1111_1111, 4'hF, 1'b1, 2'b11);
        wr("wmis", 32'h8000_0012, 4'hB, 3'd2, 32'h1111_1111, 4'hF, 1'b1, 2'b10);
        rd("unchanged", 32'h8000_0010, 4'd9, 3'd2, 32'hDEAD_AAEF, 2'b00, 1'b1);

        // alternation of simultaneous requests after a fresh reset
        do_reset();
        bus.araddr = 32'h8000_0010; bus.arid = 4'd3; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0014; bus.awid = 4'd5; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        #1;
        check("arb1.arready", 32'(bus.arready), 32'd1);
        check("arb1.awready", 32'(bus.awready), 32'd0);
        step();
        bus.arvalid = 1'b0;
        check("arb1.awready_busy", 32'(bus.awready), 32'd0);
        r_resp(d, r, i, lat);
        check("arb1.rid", 32'(i), 32'd3);
        check("arb1.rdata", d, 32'hDEAD_AAEF);
        bus.arvalid = 1'b1;
        #1;
        check("arb2.arready", 32'(bus.arready), 32'd0);
        check("arb2.awready", 32'(bus.awready), 32'd1);
        step();
        bus.awvalid = 1'b0;
        wb(32'hCAFE_F00D, 4'hF, 1'b1, r, i, lat);
        check("arb2.bresp", 32'(r), 32'd0);
        check("arb2.bid", 32'(i), 32'd5);
        bus.araddr = 32'h8000_0014;
        bus.awvalid = 1'b1;
        #1;
        check("arb3.arready", 32'(bus.arready), 32'd1);
        check("arb3.awready", 32'(bus.awready), 32'd0);
        step();
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        r_resp(d, r, i, lat);
        check("arb3.rid", 32'(i), 32'd3);
        check("arb3.rdata", d, 32'hCAFE_F00D);

        // response stall with rready low
        ar_req(32'h8000_0014, 4'd7, 3'd2);
        lat = 0;
        while (!bus.rvalid && lat < 50) begin step(); lat++; end
        bus.araddr = 32'h8000_0010;
        bus.arvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("stall.rvalid", 32'(bus.rvalid), 32'd1);
            check("stall.rdata", bus.rdata, 32'hCAFE_F00D);
            check("stall.rresp", 32'(bus.rresp), 32'd0);
            check("stall.arready", 32'(bus.arready), 32'd0);
            step();
        end
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("stall.done", 32'(bus.rvalid), 32'd0);

        // reset during W_WAIT
        wr("pre", 32'h8000_0020, 4'd1, 3'd2, 32'h1234_5678, 4'hF, 1'b1, 2'b00);
        aw_req(32'h8000_0024, 4'd2, 3'd2);
        bus.wdata = 32'h5555_5555; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        step();
        rstn = 1'b0;
        #1;
        check("abw.bvalid_rst", 32'(bus.bvalid), 32'd0);
        check("abw.arready_rst", 32'(bus.arready), 32'd0);
        step();
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("abw.bvalid", 32'(bus.bvalid), 32'd0);
            step();
        end

        // reset during W_DATA, W arrives while reset is held
        aw_req(32'h8000_0020, 4'd3, 3'd2);
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        rstn = 1'b0;
        step();
        check("abd.bvalid_rst", 32'(bus.bvalid), 32'd0);
        bus.wvalid = 1'b0;
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("abd.bvalid", 32'(bus.bvalid), 32'd0);
            step();
        end
        rd("abd.read", 32'h8000_0020, 4'd4, 3'd2, 32'h1234_5678, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060184_axi_sram.md
# ysyx_23060184_axi_sram

AXI4 single-beat responder backing a word-addressed SRAM array, the subordinate end of the core's SoC memory initiator. It accepts one read (AR→R) or one write (AW→W→B) transaction at a time, applies fixed access latency, and merges byte-lane writes under `wstrb`. It gives the LSU/IFU memory path a self-contained memory model for simulation and small FPGA builds.

## Interface
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, data bus width (only 32 supported).
- `ID_WIDTH`, 4, transaction ID width.
- `DEPTH`, 1024, SRAM size in 32-bit words (power of two).
- `BASE`, 32'h8000_0000, byte address of word 0.
- `LATENCY`, 2, wait cycles between request acceptance and response valid (0 allowed).
- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `araddr` in ADDR_WIDTH; `arid` in ID_WIDTH; `arsize` in 3; `arvalid` in 1; `arready` out 1.
- `rdata` out 32; `rresp` out 2; `rid` out ID_WIDTH; `rlast` out 1; `rvalid` out 1; `rready` in 1.
- `awaddr` in ADDR_WIDTH; `awid` in ID_WIDTH; `awsize` in 3; `awvalid` in 1; `awready` out 1.
- `wdata` in 32; `wstrb` in 4; `wlast` in 1; `wvalid` in 1; `wready` out 1.
- `bresp` out 2; `bid` out ID_WIDTH; `bvalid` out 1; `bready` in 1.

## Operation
- FSM states: IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP.
- IDLE: `arready`=`awready`=1; all other readys/valids 0.
- Arbitration when `arvalid` and `awvalid` both high in IDLE: alternate; flag `last_rd` (reset 0) — if `last_rd`=0 read wins, else write wins. Loser's ready is forced 0 that cycle. Flag updates on every accepted request (1 on read, 0 on write).
- AR handshake: latch `araddr`, `arid`, `arsize`; go R_WAIT, load latency counter with LATENCY. Counter decrements each cycle; at 0 enter R_RESP (LATENCY=0: go directly to R_RESP).
- Read response: `rdata` = full aligned word `mem[(addr-BASE)>>2]` (byte lanes in natural AXI positions; initiator extracts lanes); `rlast`=1; `rid`=latched ID.
- AW handshake: latch `awaddr`, `awid`, `awsize`; go W_DATA with `wready`=1.
- W handshake: for each i with `wstrb[i]`=1 write byte lane i into the addressed word; bytes with strobe 0 unchanged. Then W_WAIT with latency counter, then B_RESP, `bid`=latched ID.
- Response codes (priority order): address outside [BASE, BASE+4*DEPTH) → DECERR 2'b11; misaligned (`size`=1 and addr[0]=1, or `size`=2 and addr[1:0]≠0, or `size`>2) → SLVERR 2'b10; write with `wlast`=0 → SLVERR; else OKAY 2'b00. Any error: no memory update, `rdata`=0.
- R_RESP/B_RESP: valid held, payload stable, until ready; on handshake return to IDLE.
- Memory contents not reset; all control and output registers are.

## Timing
- Reset values: `arready`=`awready`=1 after release (0 while `rstn` low), `wready`=`rvalid`=`bvalid`=0, `rdata`=0, `rresp`=`bresp`=0, `rid`=`bid`=0, `rlast`=0, state IDLE, counter 0.
- Read: AR handshake edge T → `rvalid` high from T+1+LATENCY; `arready` low from T+1 until the cycle after the R handshake.
- Write: AW handshake T → `wready` high T+1; W handshake edge Tw writes memory at Tw → `bvalid` high from Tw+1+LATENCY.
- `wvalid` arriving before/with AW is not accepted (`wready`=0 in IDLE); it is taken in W_DATA.
- `rready`/`bready` held low: responder stalls indefinitely, no new request accepted.
- Read-after-write to same word: read accepted after B handshake returns new data.
- `rstn` asserted mid-transaction: immediate abort, outputs to reset values, no response issued; a pending W not yet handshaken does not modify memory.

## Test plan
- Write `awaddr`=0x8000_0010, `wdata`=0xDEADBEEF, `wstrb`=4'hF, then read same: `bresp`=0, `rdata`=0xDEADBEEF, `rresp`=0, `rvalid` at T+3 with LATENCY=2.
- Byte write `awsize`=0, addr 0x8000_0011, `wdata`=0x0000_AA00, `wstrb`=4'b0010 over 0xDEADBEEF → read returns 0xDEADAAEF.
- Read 0x9000_0000 → `rresp`=2'b11, `rdata`=0; `arsize`=2 at 0x8000_0002 → `rresp`=2'b10; write with `wlast`=0 → `bresp`=2'b10, memory unchanged.
- `arvalid` and `awvalid` raised together after reset, twice back-to-back: first read granted, then write, then read (alternation); IDs echoed (`arid`=3 → `rid`=3, `awid`=5 → `bid`=5).
- `rready` held low 10 cycles after `rvalid`: `rvalid`, `rdata`, `rresp` stable all 10 cycles, `arready` stays 0.
- Pulse `rstn` low during W_WAIT and during W_DATA (before W handshake): `bvalid` never asserts; in the second case target word unchanged on later read.
